// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : MIPS write-back stage. Holds the MEM/WB pipeline register,
//            selects the result (link / extended load / ALU), and is the
//            only driver of the register-file write port. The registered
//            outputs also serve as the WB forwarding source for the hazard
//            unit. A retired-instruction counter is kept for debug.
// Ports    : clk, reset (sync, active-high), stall, flush
//            in_* : MEM-stage instruction fields, captured each cycle
//            RegWrite/WriteReg/WriteData : register-file write port
//            wb_valid, load_misaligned, retired_count : status
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int COUNT_W   = 32,
  parameter int SAT_COUNT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_reg_write,
  input  logic               in_mem_to_reg,
  input  logic               in_link,
  input  logic [1:0]         in_load_size,
  input  logic               in_load_unsigned,
  input  logic [1:0]         in_addr_lo,
  input  logic [31:0]        in_alu_result,
  input  logic [31:0]        in_mem_rdata,
  input  logic [31:0]        in_pc_plus8,
  input  logic [4:0]         in_write_reg,
  output logic               RegWrite,
  output logic [4:0]         WriteReg,
  output logic [31:0]        WriteData,
  output logic               wb_valid,
  output logic               load_misaligned,
  output logic [COUNT_W-1:0] retired_count
);

  localparam logic [1:0] c_SIZE_WORD = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_BYTE = 2'b10;

  // MEM/WB pipeline register fields
  logic               valid_q;
  logic               reg_write_q;
  logic               mem_to_reg_q;
  logic               link_q;
  logic [1:0]         load_size_q;
  logic               load_unsigned_q;
  logic [1:0]         addr_lo_q;
  logic [31:0]        alu_result_q;
  logic [31:0]        mem_rdata_q;
  logic [31:0]        pc_plus8_q;
  logic [4:0]         write_reg_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  logic               misaligned_w;
  logic [7:0]         byte_w;
  logic [15:0]        half_w;
  logic [31:0]        load_data_w;
  logic               retire_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      link_q          <= 1'b0;
      load_size_q     <= 2'b00;
      load_unsigned_q <= 1'b0;
      addr_lo_q       <= 2'b00;
      alu_result_q    <= 32'd0;
      mem_rdata_q     <= 32'd0;
      pc_plus8_q      <= 32'd0;
      write_reg_q     <= 5'd0;
    end else if (flush) begin
      // Only the control bits matter for a bubble; data fields are left as is.
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall) begin
      valid_q         <= in_valid;
      reg_write_q     <= in_reg_write;
      mem_to_reg_q    <= in_mem_to_reg;
      link_q          <= in_link;
      load_size_q     <= in_load_size;
      load_unsigned_q <= in_load_unsigned;
      addr_lo_q       <= in_addr_lo;
      alu_result_q    <= in_alu_result;
      mem_rdata_q     <= in_mem_rdata;
      pc_plus8_q      <= in_pc_plus8;
      write_reg_q     <= in_write_reg;
    end
  end

  // Misalignment only applies to a real load whose result is actually used.
  always_comb begin
    misaligned_w = 1'b0;
    if (valid_q && mem_to_reg_q && !link_q) begin
      case (load_size_q)
        c_SIZE_HALF: misaligned_w = addr_lo_q[0];
        c_SIZE_BYTE: misaligned_w = 1'b0;
        default:     misaligned_w = (addr_lo_q != 2'b00); // word and 11
      endcase
    end
  end

  // Lane extraction and extension (little-endian lanes)
  always_comb begin
    byte_w = mem_rdata_q[8*addr_lo_q +: 8];
    half_w = addr_lo_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
    case (load_size_q)
      c_SIZE_HALF: load_data_w = {{16{half_w[15] & ~load_unsigned_q}}, half_w};
      c_SIZE_BYTE: load_data_w = {{24{byte_w[7] & ~load_unsigned_q}}, byte_w};
      c_SIZE_WORD: load_data_w = mem_rdata_q;
      default:     load_data_w = mem_rdata_q;
    endcase
  end

  always_comb begin
    if (link_q) begin
      WriteData = pc_plus8_q;
    end else if (mem_to_reg_q) begin
      WriteData = load_data_w;
    end else begin
      WriteData = alu_result_q;
    end
  end

  assign RegWrite        = valid_q & reg_write_q & (write_reg_q != 5'd0) & ~misaligned_w;
  assign WriteReg        = write_reg_q;
  assign wb_valid        = valid_q;
  assign load_misaligned = misaligned_w;

  // An instruction retires on the edge where it leaves WB, so a stalled
  // instruction is counted exactly once.
  assign retire_w = valid_q & ~stall & ~misaligned_w;

  generate
    if (SAT_COUNT != 0) begin : g_sat
      always_comb begin
        count_d = count_q;
        if (retire_w && !(&count_q)) begin
          count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
      end
    end else begin : g_wrap
      always_comb begin
        count_d = count_q;
        if (retire_w) begin
          count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed self-checking bench for wb_stage. One 32-bit wrapping
//            instance plus two 4-bit instances (wrapping and saturating)
//            share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        in_valid, in_reg_write, in_mem_to_reg, in_link;
  logic [1:0]  in_load_size, in_addr_lo;
  logic        in_load_unsigned;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus8;
  logic [4:0]  in_write_reg;

  logic        RegWrite, wb_valid, load_misaligned;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData, retired_count;

  logic        w_rw, w_v, w_m;
  logic [4:0]  w_wr;
  logic [31:0] w_wd;
  logic [3:0]  w_cnt;
  logic        s_rw, s_v, s_m;
  logic [4:0]  s_wr;
  logic [31:0] s_wd;
  logic [3:0]  s_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_stage #(.COUNT_W(32), .SAT_COUNT(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_link(in_link), .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus8(in_pc_plus8), .in_write_reg(in_write_reg),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .wb_valid(wb_valid), .load_misaligned(load_misaligned), .retired_count(retired_count)
  );

  wb_stage #(.COUNT_W(4), .SAT_COUNT(0)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_link(in_link), .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus8(in_pc_plus8), .in_write_reg(in_write_reg),
    .RegWrite(w_rw), .WriteReg(w_wr), .WriteData(w_wd),
    .wb_valid(w_v), .load_misaligned(w_m), .retired_count(w_cnt)
  );

  wb_stage #(.COUNT_W(4), .SAT_COUNT(1)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_link(in_link), .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus8(in_pc_plus8), .in_write_reg(in_write_reg),
    .RegWrite(s_rw), .WriteReg(s_wr), .WriteData(s_wd),
    .wb_valid(s_v), .load_misaligned(s_m), .retired_count(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                       input logic [1:0] sz, input logic uns, input logic [1:0] lo,
                       input logic [31:0] alu, input logic [31:0] rd_data,
                       input logic [31:0] pc8, input logic [4:0] rd);
    in_valid         = v;
    in_reg_write     = rw;
    in_mem_to_reg    = m2r;
    in_link          = lnk;
    in_load_size     = sz;
    in_load_unsigned = uns;
    in_addr_lo       = lo;
    in_alu_result    = alu;
    in_mem_rdata     = rd_data;
    in_pc_plus8      = pc8;
    in_write_reg     = rd;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, val, 32'h0, 32'h0, rd);
  endtask

  task automatic load_op(input logic [1:0] sz, input logic uns, input logic [1:0] lo);
    drive(1'b1, 1'b1, 1'b1, 1'b0, sz, uns, lo, 32'hAAAA_5555, 32'h80FF_7F01, 32'h0, 5'd6);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    step();
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_writereg", {27'd0, WriteReg}, 32'd0);
    chk("rst_writedata", WriteData, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_misaligned", {31'd0, load_misaligned}, 32'd0);
    chk("rst_count", retired_count, 32'd0);

    // ALU op rd=5
    reset = 1'b0;
    alu_op(5'd5, 32'h1234_5678);
    step();
    chk("alu_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("alu_writereg", {27'd0, WriteReg}, 32'd5);
    chk("alu_writedata", WriteData, 32'h1234_5678);
    chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu_count", retired_count, 32'd0);

    // Loads from rdata = 0x80FF_7F01
    load_op(2'b10, 1'b0, 2'd3);
    step();
    chk("lb3_data", WriteData, 32'hFFFF_FF80);
    chk("lb3_count", retired_count, 32'd1);
    load_op(2'b10, 1'b1, 2'd3);
    step();
    chk("lbu3_data", WriteData, 32'h0000_0080);
    load_op(2'b01, 1'b0, 2'd2);
    step();
    chk("lh2_data", WriteData, 32'hFFFF_80FF);
    load_op(2'b01, 1'b1, 2'd0);
    step();
    chk("lhu0_data", WriteData, 32'h0000_7F01);
    chk("lhu0_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("lhu0_count", retired_count, 32'd4);

    // Misaligned word and half loads
    load_op(2'b00, 1'b0, 2'd2);
    step();
    chk("lw2_misaligned", {31'd0, load_misaligned}, 32'd1);
    chk("lw2_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("lw2_count", retired_count, 32'd5);
    load_op(2'b01, 1'b0, 2'd1);
    step();
    chk("lh1_misaligned", {31'd0, load_misaligned}, 32'd1);
    chk("lh1_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("lh1_count", retired_count, 32'd5);

    // jal: link overrides mem_to_reg and the misaligned address is ignored
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'd2, 32'h0, 32'h0, 32'h0040_0008, 5'd31);
    step();
    chk("jal_data", WriteData, 32'h0040_0008);
    chk("jal_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("jal_writereg", {27'd0, WriteReg}, 32'd31);
    chk("jal_misaligned", {31'd0, load_misaligned}, 32'd0);
    chk("jal_count", retired_count, 32'd5);

    // Write to $0
    alu_op(5'd0, 32'h0000_DEAD);
    step();
    chk("r0_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("r0_count", retired_count, 32'd6);

    // Stall held 3 cycles over a valid op
    alu_op(5'd7, 32'hCAFE_BABE);
    step();
    chk("pre_stall_count", retired_count, 32'd7);
    stall = 1'b1;
    alu_op(5'd8, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_data", WriteData, 32'hCAFE_BABE);
      chk("stall_writereg", {27'd0, WriteReg}, 32'd7);
      chk("stall_regwrite", {31'd0, RegWrite}, 32'd1);
      chk("stall_count", retired_count, 32'd7);
    end
    stall = 1'b0;
    step();
    chk("post_stall_writereg", {27'd0, WriteReg}, 32'd8);
    chk("post_stall_count", retired_count, 32'd8);

    // Flush together with stall: flush wins, held op is dropped uncounted
    stall = 1'b1; flush = 1'b1;
    alu_op(5'd9, 32'h2222_2222);
    step();
    chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("flush_count", retired_count, 32'd8);
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    chk("bubble_count", retired_count, 32'd8);

    // Counter wrap vs saturate at COUNT_W=4
    reset = 1'b1;
    step();
    chk("rst2_wrap_count", {28'd0, w_cnt}, 32'd0);
    chk("rst2_sat_count", {28'd0, s_cnt}, 32'd0);
    reset = 1'b0;
    alu_op(5'd1, 32'h0000_0001);
    for (int i = 0; i < 16; i++) step();
    chk("wrap_15", {28'd0, w_cnt}, 32'd15);
    chk("sat_15", {28'd0, s_cnt}, 32'd15);
    step();
    chk("wrap_0", {28'd0, w_cnt}, 32'd0);
    chk("sat_hold", {28'd0, s_cnt}, 32'd15);
    chk("main_16", retired_count, 32'd16);

    // Reset asserted mid-stall wins
    reset = 1'b1; stall = 1'b1;
    step();
    chk("rst3_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst3_writereg", {27'd0, WriteReg}, 32'd0);
    chk("rst3_writedata", WriteData, 32'd0);
    chk("rst3_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst3_count", retired_count, 32'd0);
    chk("rst3_sat_count", {28'd0, s_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
